// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port synchronous RAM between the SC/MP CPU bus and a
// debug/loader master (e.g. a UART monitor). Runs on the RAM clock, which is
// at least twice the CPU clock, and sits between the CPU strobes and the RAM.
//
//   - The CPU has priority. A debug transaction gets a fixed two-clock slot
//     (address phase, then data phase). The CPU is held off (cpu_hold) for the
//     length of the slot, and the slot is never aborted.
//   - A CPU write to the ROM image or to the keyboard/display window is
//     dropped and reported with a one-clock wp_err pulse. Debug writes bypass
//     this protection so the loader can fill the ROM image.
//
// Ports
//   clk, reset                 RAM clock; asynchronous active-high reset
//   cpu_rd, cpu_wr             CPU strobes (level, many clk long)
//   cpu_addr, cpu_wdata        CPU address / write data
//   cpu_rdata                  registered CPU read data
//   cpu_hold                   high while a debug slot owns the RAM
//   dbg_req, dbg_ack           four-phase debug handshake
//   dbg_we, dbg_addr,
//   dbg_wdata, dbg_rdata       debug transaction fields / read data
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata       RAM port (mem_rdata has one clock of latency)
//   wp_err                     one-clock pulse on a suppressed CPU write
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int              AW     = 16,
    parameter int              DW     = 8,
    parameter logic [AW-1:0]   ROM_LO = 16'h7800,
    parameter logic [AW-1:0]   ROM_HI = 16'h7FFF,
    parameter logic [AW-1:0]   IO_LO  = 16'h7000,
    parameter logic [AW-1:0]   IO_HI  = 16'h70FF
) (
    input  logic          clk,
    input  logic          reset,
    // CPU side
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    // debug / loader side
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    // RAM side
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          wp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CPU   = 2'd1,
        DBG_A = 2'd2,
        DBG_D = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic   cpu_act;
    logic   prot;
    logic   dbg_slot;
    logic   wr_done;

    assign cpu_act  = cpu_rd | cpu_wr;
    assign prot     = ((cpu_addr >= ROM_LO) && (cpu_addr <= ROM_HI)) ||
                      ((cpu_addr >= IO_LO)  && (cpu_addr <= IO_HI));
    assign dbg_slot = (state == DBG_A) || (state == DBG_D);

    // ------------------------------------------------------------------
    // Next-state logic. The CPU wins in IDLE; a debug slot is only granted
    // once the previous handshake has fully closed (dbg_ack low).
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cpu_act)
                    state_next = CPU;
                else if (dbg_req && !dbg_ack)
                    state_next = DBG_A;
            end
            CPU: begin
                if (!cpu_act)
                    state_next = IDLE;
            end
            DBG_A: state_next = DBG_D;
            // A CPU strobe that arrived during the slot is served directly,
            // without passing through IDLE.
            DBG_D: state_next = cpu_act ? CPU : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port. Outside the debug slot the CPU address is always presented,
    // so the RAM prefetches the CPU location while still in IDLE and read
    // data is ready one clock after entering CPU.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = dbg_slot ? dbg_addr  : cpu_addr;
        mem_wdata = dbg_slot ? dbg_wdata : cpu_wdata;
        mem_we    = 1'b0;
        unique case (state)
            // wr_done limits a long write strobe to a single RAM write.
            CPU:     mem_we = cpu_wr && !prot && !wr_done;
            // Protection deliberately not applied to the loader.
            DBG_A:   mem_we = dbg_we;
            default: mem_we = 1'b0;
        endcase
    end

    assign cpu_hold = dbg_slot;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_done   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            dbg_ack   <= 1'b0;
            wp_err    <= 1'b0;
        end else begin
            state <= state_next;

            // Armed by every pass through IDLE. It goes high after the first
            // CPU clock, so a strobe writes during its first clock only.
            if (state == IDLE)
                wr_done <= 1'b0;
            else if (state == CPU)
                wr_done <= 1'b1;

            if (state == CPU)
                cpu_rdata <= mem_rdata;

            // The data phase returns what the RAM registered during the
            // address phase. The ack then stays up until the requester drops
            // its request.
            if (state == DBG_D) begin
                dbg_rdata <= mem_rdata;
                dbg_ack   <= 1'b1;
            end else if (dbg_ack && !dbg_req) begin
                dbg_ack   <= 1'b0;
            end

            // Flag a protected write once, on the edge that enters CPU.
            wp_err <= (state_next == CPU) && (state != CPU) && cpu_wr && prot;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Self-checking bench for ram_arbiter. It contains the following parts:
//   - A registered RAM that is the DUT's environment. It is read-first and
//     has one clock of read latency.
//   - A golden memory. It is updated only by the transactions that the
//     ownership rules permit.
//   - An ownership/slot model that gives the expected outputs every cycle.
//   - Directed scenarios with literal expectations.
//   - A randomized phase with concurrent CPU and debug masters.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_hold;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [7:0]  dbg_wdata = '0;
    logic        dbg_ack;
    logic [7:0]  dbg_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        wp_err;

    logic [7:0]  ram  [0:65535];
    logic [7:0]  gold [0:65535];

    int n_cmp = 0, n_bad = 0;
    int we_cnt = 0, wp_cnt = 0, hold_cnt = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wp_err(wp_err)
    );

    // RAM environment: read-first, one clock of read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic bit prot(input logic [15:0] a);
        return (a >= 16'h7800 && a <= 16'h7FFF) || (a >= 16'h7000 && a <= 16'h70FF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preset(input logic [15:0] a, input logic [7:0] v);
        ram[a]  = v;
        gold[a] = v;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The model tracks the following:
    //   - who owns the RAM (CPU or a debug slot);
    //   - the remaining length of the debug slot;
    //   - how long the CPU has held the RAM.
    // From these it applies the transaction rules to the golden memory.
    // ------------------------------------------------------------------
    bit         m_cpu = 0;       // CPU currently owns the RAM
    int         m_slot = 0;      // debug clocks left in the slot: 2, 1, 0 = none
    int         m_age = 0;       // clocks since the CPU was granted
    bit         m_from_dbg = 0;  // the CPU grant followed a debug slot directly
    bit         m_ack = 0;
    bit         m_wp = 0;
    logic [7:0] m_crd = '0, m_drd = '0, m_dold = '0;

    initial begin : model
        bit act, g_cpu, s_cpu, g_dbg;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_cpu = 0; m_slot = 0; m_age = 0; m_from_dbg = 0;
                m_ack = 0; m_wp = 0; m_crd = '0; m_drd = '0;
            end else begin
                act   = cpu_rd | cpu_wr;
                g_cpu = act && ((m_slot == 0 && !m_cpu) || m_slot == 1);
                s_cpu = m_cpu && act;
                g_dbg = !m_cpu && m_slot == 0 && !act && dbg_req && !m_ack;
                if (m_cpu && m_age == 0 && cpu_wr && !prot(cpu_addr))
                    gold[cpu_addr] = cpu_wdata;
                if (m_slot == 2) begin
                    m_dold = gold[dbg_addr];
                    if (dbg_we) gold[dbg_addr] = dbg_wdata;
                end
                if (m_cpu) m_crd = mem_rdata;
                if (m_slot == 1) begin
                    m_drd = m_dold;
                    m_ack = 1;
                end else if (m_ack && !dbg_req) begin
                    m_ack = 0;
                end
                m_wp = g_cpu && cpu_wr && prot(cpu_addr);
                if (g_cpu) begin
                    m_from_dbg = (m_slot == 1);
                    m_age = 0;
                end else if (s_cpu) begin
                    m_age++;
                end
                m_cpu  = g_cpu || s_cpu;
                m_slot = (m_slot == 2) ? 1 : (g_dbg ? 2 : 0);
            end
        end
    end

    // Per-cycle compare at the falling edge.
    initial begin : compare
        bit         e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        forever begin
            @(negedge clk);
            e_we   = (m_cpu && m_age == 0 && cpu_wr && !prot(cpu_addr)) || (m_slot == 2 && dbg_we);
            e_addr = (m_slot != 0) ? dbg_addr  : cpu_addr;
            e_wd   = (m_slot != 0) ? dbg_wdata : cpu_wdata;
            chk("mem_we",    mem_we,    e_we);
            chk("cpu_hold",  cpu_hold,  m_slot != 0);
            chk("mem_addr",  mem_addr,  e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("dbg_ack",   dbg_ack,   m_ack);
            chk("wp_err",    wp_err,    m_wp);
            chk("cpu_rdata", cpu_rdata, m_crd);
            chk("dbg_rdata", dbg_rdata, m_drd);
            if (m_cpu && cpu_rd && !cpu_wr && m_age >= (m_from_dbg ? 2 : 1))
                chk("cpu_read_value", cpu_rdata, gold[cpu_addr]);
            if (mem_we)   we_cnt++;
            if (wp_err)   wp_cnt++;
            if (cpu_hold) hold_cnt++;
        end
    end

    // Four-phase debug transaction; lat = edges from request to ack.
    task automatic dbg_txn(input bit we, input logic [15:0] a, input logic [7:0] d, output int lat);
        int n;
        dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
        lat = 0;
        while (!dbg_ack && lat < 50) begin
            tick(1);
            lat++;
        end
        chk("dbg_ack_timeout", dbg_ack, 1'b1);
        dbg_req = 1'b0;
        n = 0;
        while (dbg_ack && n < 10) begin
            tick(1);
            n++;
        end
        chk("dbg_ack_release", dbg_ack, 1'b0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'($urandom_range(0, 15));
            1: return 16'h7000 + 16'($urandom_range(0, 3));
            2: return 16'h70FF;
            3: return 16'h7100;
            4: return 16'h77FF;
            5: return 16'h7800 + 16'($urandom_range(0, 3));
            6: return 16'h7FFF;
            default: return 16'h8000;
        endcase
    endfunction

    initial begin : main
        int lat;
        int bad;
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = 8'($urandom);
            gold[i] = ram[i];
        end
        preset(16'h7805, 8'hC4);
        preset(16'h7810, 8'h3C);
        preset(16'h7700, 8'h00);
        preset(16'h7800, 8'h00);
        preset(16'h0000, 8'h77);
        preset(16'h0001, 8'h5E);
        preset(16'h0002, 8'h22);
        preset(16'h0003, 8'h33);
        preset(16'h0010, 8'h11);

        // Reset state
        tick(2);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_dbg_rdata", dbg_rdata, 8'h00);
        chk("rst_dbg_ack",   dbg_ack,   1'b0);
        chk("rst_wp_err",    wp_err,    1'b0);
        chk("rst_mem_we",    mem_we,    1'b0);
        chk("rst_cpu_hold",  cpu_hold,  1'b0);
        reset = 1'b0;
        tick(1);

        // CPU read of the ROM image
        we_cnt = 0;
        cpu_addr = 16'h7805; cpu_rd = 1'b1;
        tick(2);
        chk("rd7805_data", cpu_rdata, 8'hC4);
        tick(1);
        cpu_rd = 1'b0;
        tick(2);
        chk("rd7805_no_we", we_cnt, 0);

        // Protected write is suppressed; an unprotected write lands once
        we_cnt = 0; wp_cnt = 0;
        cpu_addr = 16'h7810; cpu_wdata = 8'h55; cpu_wr = 1'b1;
        tick(4);
        cpu_wr = 1'b0;
        tick(2);
        chk("wp_we_count", we_cnt, 0);
        chk("wp_pulses",   wp_cnt, 1);
        chk("wp_ram",      ram[16'h7810], 8'h3C);
        we_cnt = 0;
        cpu_addr = 16'h7700; cpu_wdata = 8'h55; cpu_wr = 1'b1;
        tick(3);
        cpu_wr = 1'b0;
        tick(2);
        chk("wr7700_we_count", we_cnt, 1);
        chk("wr7700_ram",      ram[16'h7700], 8'h55);

        // Debug write, read back, write into ROM image
        dbg_txn(1'b1, 16'h0000, 8'h08, lat);
        chk("dbg_wr_latency", lat, 3);
        dbg_txn(1'b0, 16'h0000, 8'h00, lat);
        chk("dbg_rd_latency", lat, 3);
        chk("dbg_rd_data",    dbg_rdata, 8'h08);
        dbg_txn(1'b1, 16'h7800, 8'hAA, lat);
        chk("dbg_rom_latency", lat, 3);
        chk("dbg_rom_ram",     ram[16'h7800], 8'hAA);

        // Simultaneous CPU read and debug request: the CPU goes first
        hold_cnt = 0;
        cpu_addr = 16'h0004; cpu_rd = 1'b1;
        dbg_we = 1'b0; dbg_addr = 16'h0001; dbg_req = 1'b1;
        tick(4);
        chk("simul_no_hold", hold_cnt, 0);
        chk("simul_no_ack",  dbg_ack, 1'b0);
        cpu_rd = 1'b0;
        tick(1);
        chk("simul_idle_hold", cpu_hold, 1'b0);
        tick(1);
        chk("simul_slot_hold", cpu_hold, 1'b1);
        tick(2);
        chk("simul_ack",   dbg_ack, 1'b1);
        chk("simul_rdata", dbg_rdata, 8'h5E);
        dbg_req = 1'b0;
        tick(2);

        // CPU read arrives during DBG_A
        dbg_we = 1'b0; dbg_addr = 16'h0002; dbg_req = 1'b1;
        tick(1);
        chk("mid_hold_a", cpu_hold, 1'b1);
        hold_cnt = 0;
        cpu_addr = 16'h0003; cpu_rd = 1'b1;
        tick(4);
        chk("mid_hold_count", hold_cnt, 2);
        chk("mid_cpu_rdata",  cpu_rdata, 8'h33);
        chk("mid_dbg_rdata",  dbg_rdata, 8'h22);
        cpu_rd = 1'b0; dbg_req = 1'b0;
        tick(2);

        // Reset during the address phase of a debug write
        dbg_we = 1'b1; dbg_addr = 16'h0010; dbg_wdata = 8'h5A; dbg_req = 1'b1;
        tick(1);
        reset = 1'b1; dbg_req = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_slot_ram",  ram[16'h0010], 8'h11);
        chk("rst_slot_ack",  dbg_ack, 1'b0);
        chk("rst_slot_hold", cpu_hold, 1'b0);
        dbg_txn(1'b1, 16'h0010, 8'h5A, lat);
        chk("rst_retry_latency", lat, 3);
        chk("rst_retry_ram",     ram[16'h0010], 8'h5A);

        // Randomized concurrent traffic
        fork
            begin : cpu_drv
                for (int i = 0; i < 150; i++) begin
                    int len, gap;
                    bit w;
                    len = $urandom_range(1, 6);
                    gap = $urandom_range(1, 4);
                    w   = 1'($urandom_range(0, 1));
                    cpu_addr  = pick();
                    cpu_wdata = 8'($urandom);
                    if (w) cpu_wr = 1'b1;
                    else   cpu_rd = 1'b1;
                    tick(len);
                    cpu_rd = 1'b0; cpu_wr = 1'b0;
                    tick(gap);
                end
            end
            begin : dbg_drv
                for (int i = 0; i < 80; i++) begin
                    int dl;
                    tick($urandom_range(0, 5));
                    dbg_txn(1'($urandom_range(0, 1)), pick(), 8'($urandom), dl);
                end
            end
        join
        tick(3);

        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (ram[i] !== gold[i]) bad++;
        chk("ram_vs_model", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
